// File: rtl/regfile_dump_reader.sv
// Streams a contiguous range of register-file words over valid/ready with index,
// last flag and a running XOR checksum, using one combinational read port.
module regfile_dump_reader #(
   parameter int N    = 32,
   parameter int ADDR = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [ADDR-1:0] first_reg_i,
   input  logic [ADDR-1:0] last_reg_i,
   output logic [ADDR-1:0] Rd_Addr_o,
   input  logic [N-1:0]    Rd_Data_i,
   output logic [N-1:0]    data_o,
   output logic [ADDR-1:0] index_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            last_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            error_o,
   output logic [N-1:0]    checksum_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR-1:0] ptr_q, ptr_d;
   logic [ADDR-1:0] last_reg_q, last_reg_d;
   logic [N-1:0]    data_d, checksum_d;
   logic [ADDR-1:0] index_d;
   logic            valid_d, last_d, error_d;
   logic            load_word;
   logic            at_last;
   logic            handshake;

   assign at_last   = (ptr_q == last_reg_q);
   assign handshake = valid_o & ready_i;

   assign Rd_Addr_o = ptr_q;
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case below can leave one unassigned and infer a latch.
      state_d    = state_q;
      ptr_d      = ptr_q;
      last_reg_d = last_reg_q;
      data_d     = data_o;
      index_d    = index_o;
      valid_d    = valid_o;
      last_d     = last_o;
      checksum_d = checksum_o;
      error_d    = 1'b0;
      load_word  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (first_reg_i <= last_reg_i) begin
                  last_reg_d = last_reg_i;
                  ptr_d      = first_reg_i;
                  checksum_d = '0;
                  state_d    = FETCH;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               load_word = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            // Abort outranks the handshake: a word offered in the abort cycle is not counted.
            if (abort_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = IDLE;
            end else if (handshake) begin
               checksum_d = checksum_o ^ data_o;
               if (last_o) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The pointer parks on the last index, so a range ending at the top never wraps.
      if (load_word) begin
         data_d  = Rd_Data_i;
         index_d = ptr_q;
         last_d  = at_last;
         valid_d = 1'b1;
         if (!at_last) begin
            ptr_d = ptr_q + ADDR'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking updates so every flop samples the
      // pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         last_reg_q <= '0;
         data_o     <= '0;
         index_o    <= '0;
         valid_o    <= 1'b0;
         last_o     <= 1'b0;
         error_o    <= 1'b0;
         checksum_o <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         last_reg_q <= last_reg_d;
         data_o     <= data_d;
         index_o    <= index_d;
         valid_o    <= valid_d;
         last_o     <= last_d;
         error_o    <= error_d;
         checksum_o <= checksum_d;
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words are queued at start,
// a negedge monitor compares every offered word and pops on each accepted one.
module tb_regfile_dump_reader;
   localparam int N    = 32;
   localparam int ADDR = 5;
   localparam int NREG = 1 << ADDR;

   logic            clk = 1'b0;
   logic            reset, start_i, abort_i, ready_i;
   logic [ADDR-1:0] first_reg_i, last_reg_i, Rd_Addr_o, index_o;
   logic [N-1:0]    Rd_Data_i, data_o, checksum_o;
   logic            valid_o, last_o, busy_o, done_o, error_o;

   logic [N-1:0] regs [NREG];
   assign Rd_Data_i = regs[Rd_Addr_o];

   regfile_dump_reader #(.N(N), .ADDR(ADDR)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
      .first_reg_i(first_reg_i), .last_reg_i(last_reg_i),
      .Rd_Addr_o(Rd_Addr_o), .Rd_Data_i(Rd_Data_i),
      .data_o(data_o), .index_o(index_o), .valid_o(valid_o), .ready_i(ready_i),
      .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .checksum_o(checksum_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR-1:0] idx;
      logic [N-1:0]    data;
      logic            last;
   } word_t;

   word_t        exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           n_acc = 0;
   int           done_cnt = 0;
   int           last_hs_cyc = -10;
   int           ready_mode = 0;
   int           pat = 0;
   logic [N-1:0] last_ck = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every offered word must match the queue head; pop on acceptance.
   always @(negedge clk) begin
      if (!reset && done_o) done_cnt++;
      if (!reset && valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got index %0d data %h, expected no word (cycle %0d)",
                     index_o, data_o, cyc);
         end else begin
            check("word_data", data_o, exp_q[0].data);
            check("word_index", N'(index_o), N'(exp_q[0].idx));
            check("word_last", N'(last_o), N'(exp_q[0].last));
            if (ready_i && !abort_i) begin
               if (exp_q[0].last) last_hs_cyc = cyc;
               n_acc++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Downstream ready: 0 always-ready, 1 pattern 1,0,0,..., 2 random.
   initial begin
      ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = (pat % 3 == 0);
            default: ready_i = 1'($urandom_range(0, 1));
         endcase
         pat++;
      end
   end

   task automatic queue_range(input int f, input int l, output logic [N-1:0] ck);
      ck = '0;
      for (int i = f; i <= l; i++) begin
         exp_q.push_back('{idx: i[ADDR-1:0], data: regs[i], last: (i == l)});
         ck ^= regs[i];
      end
   endtask

   task automatic issue_start(input int f, input int l);
      @(posedge clk); #1;
      start_i     = 1'b1;
      first_reg_i = f[ADDR-1:0];
      last_reg_i  = l[ADDR-1:0];
      @(posedge clk); #1;
      start_i     = 1'b0;
      first_reg_i = ADDR'($urandom);
      last_reg_i  = ADDR'($urandom);
   endtask

   task automatic dump(input int f, input int l, input int mode, input bit poke);
      logic [N-1:0] exp_ck;
      int           d0, first_cyc;
      bit           seen;
      ready_mode = mode;
      queue_range(f, l, exp_ck);
      d0 = done_cnt;
      issue_start(f, l);
      @(negedge clk);
      check("fetch_no_valid", N'(valid_o), N'(0));
      check("fetch_busy", N'(busy_o), N'(1));
      @(negedge clk);
      check("first_word_latency", N'(valid_o), N'(1));
      first_cyc = cyc;
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (poke && k == 3) begin
            start_i     = 1'b1;
            first_reg_i = '0;
            last_reg_i  = ADDR'(NREG - 1);
         end
         if (poke && k == 4) start_i = 1'b0;
         if (done_o) begin
            seen = 1'b1;
            break;
         end
      end
      start_i = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done_o, expected one for range %0d..%0d", f, l);
         exp_q.delete();
      end else begin
         check("checksum", checksum_o, exp_ck);
         check("done_after_last", N'(cyc), N'(last_hs_cyc + 1));
         check("queue_drained", N'(exp_q.size()), N'(0));
         check("done_no_valid", N'(valid_o), N'(0));
         check("ptr_hold", N'(Rd_Addr_o), N'(l));
         if (mode == 0) check("back_to_back", N'(last_hs_cyc), N'(first_cyc + l - f));
         @(posedge clk); #1;
         check("done_count", N'(done_cnt - d0), N'(1));
         @(negedge clk);
         check("done_one_cycle", N'(done_o), N'(0));
         check("idle_not_busy", N'(busy_o), N'(0));
         check("checksum_hold", checksum_o, exp_ck);
      end
      last_ck = exp_ck;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_addr"}, N'(Rd_Addr_o), N'(0));
      check({tag, "_data"}, data_o, N'(0));
      check({tag, "_index"}, N'(index_o), N'(0));
      check({tag, "_valid"}, N'(valid_o), N'(0));
      check({tag, "_last"}, N'(last_o), N'(0));
      check({tag, "_busy"}, N'(busy_o), N'(0));
      check({tag, "_done"}, N'(done_o), N'(0));
      check({tag, "_error"}, N'(error_o), N'(0));
      check({tag, "_checksum"}, checksum_o, N'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] dummy_ck;
      int           d0, n0, f, l;
      reset = 1'b1; start_i = 1'b0; abort_i = 1'b0;
      first_reg_i = '0; last_reg_i = '0;
      for (int i = 0; i < NREG; i++) regs[i] = N'(i) * 32'h1111_1111;
      regs[29] = 32'h7fff_effc;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      dump(0, 31, 0, 1'b0);
      dump(5, 5, 0, 1'b0);
      dump(3, 7, 1, 1'b0);

      // Rejected start: first > last.
      @(posedge clk); #1;
      start_i = 1'b1; first_reg_i = 5'd9; last_reg_i = 5'd4;
      @(posedge clk); #1;
      start_i = 1'b0;
      check("error_pulse", N'(error_o), N'(1));
      check("error_not_busy", N'(busy_o), N'(0));
      check("error_no_valid", N'(valid_o), N'(0));
      check("error_checksum_kept", checksum_o, last_ck);
      @(posedge clk); #1;
      check("error_one_cycle", N'(error_o), N'(0));
      check("error_still_idle", N'(busy_o), N'(0));

      // Abort after three accepted words.
      ready_mode = 0;
      queue_range(0, 31, dummy_ck);
      d0 = done_cnt;
      n0 = n_acc;
      issue_start(0, 31);
      for (int k = 0; k < 100; k++) begin
         if (n_acc - n0 >= 3) break;
         @(posedge clk); #1;
      end
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      check("abort_accepted", N'(n_acc - n0), N'(3));
      check("abort_valid", N'(valid_o), N'(0));
      check("abort_last", N'(last_o), N'(0));
      check("abort_idle", N'(busy_o), N'(0));
      check("abort_checksum", checksum_o, regs[0] ^ regs[1] ^ regs[2]);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", N'(done_cnt - d0), N'(0));
      dump(0, 31, 0, 1'b0);

      // Reset in the middle of a dump.
      ready_mode = 2;
      queue_range(0, 31, dummy_ck);
      issue_start(0, 31);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_reset");
      exp_q.delete();
      reset = 1'b0;
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      check("reset_no_done", N'(done_cnt - d0), N'(0));
      check("reset_idle", N'(busy_o), N'(0));

      // Start pulsed while busy must not disturb the latched range.
      dump(10, 20, 1, 1'b1);
      dump(28, 31, 2, 1'b0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < NREG; i++) regs[i] = $urandom;
         f = $urandom_range(0, NREG - 1);
         l = $urandom_range(f, NREG - 1);
         dump(f, l, $urandom_range(0, 2), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
